// File: rtl/gerador_apostas.sv
// gerador_apostas: player-side bet sequencer for the lottery checker.
// Holds NUM_JOGOS bets of NUM_POR_JOGO 4-bit numbers, streams each bet on
// numero/insere, closes it with fim, samples the checker verdict ESPERA
// cycles later and finally signals fim_jogo/pronto. Counts winning bets.
module gerador_apostas #(
  parameter int NUM_JOGOS    = 4,
  parameter int NUM_POR_JOGO = 5,
  parameter int ESPERA       = 2,
  localparam int PROFUNDIDADE = NUM_JOGOS * NUM_POR_JOGO,
  localparam int AW           = $clog2(PROFUNDIDADE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          carga,
  input  logic [AW-1:0] endereco,
  input  logic [3:0]    dado,
  input  logic [2:0]    qtd_jogos,
  input  logic          inicia,
  input  logic [1:0]    premio,
  output logic [3:0]    numero,
  output logic          insere,
  output logic          fim,
  output logic          fim_jogo,
  output logic          ocupado,
  output logic          pronto,
  output logic [2:0]    premiados,
  output logic [1:0]    ultimo_premio
);

  localparam int PW = $clog2(NUM_POR_JOGO + 1);
  localparam int WW = $clog2(ESPERA + 1);
  localparam logic [AW:0]   PROF_L    = (AW+1)'(PROFUNDIDADE);
  localparam logic [31:0]   MAX_JOGOS = 32'(NUM_JOGOS);
  localparam logic [PW-1:0] ULT_POS   = PW'(NUM_POR_JOGO - 1);
  localparam logic [WW-1:0] ESPERA_L  = WW'(ESPERA);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ENVIA    = 3'd1,
    FECHA    = 3'd2,
    AGUARDA  = 3'd3,
    FINALIZA = 3'd4
  } estado_t;

  estado_t       state_q, state_d;
  logic [2:0]    qtd_q, qtd_d;
  logic [2:0]    jogo_q, jogo_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [WW-1:0] espera_q, espera_d;
  logic [2:0]    premiados_q, premiados_d;
  logic [1:0]    ultimo_q, ultimo_d;

  logic [3:0]    numero_q, numero_d;
  logic          insere_q, insere_d;
  logic          fim_q, fim_d;
  logic          fim_jogo_q, fim_jogo_d;
  logic          ocupado_q, ocupado_d;
  logic          pronto_q, pronto_d;

  logic [3:0]    mem_q [0:PROFUNDIDADE-1];
  logic [AW-1:0] rd_addr_s;
  logic          qtd_valida_s;

  // Bet memory: written only while idle, out-of-range addresses dropped, never cleared.
  always_ff @(posedge clock) begin
    if ((state_q == OCIOSO) && carga && ({1'b0, endereco} < PROF_L)) begin
      mem_q[endereco] <= dado;
    end
  end

  // State register: FSM state, run counters, tally and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= OCIOSO;
      qtd_q       <= 3'd0;
      jogo_q      <= 3'd0;
      pos_q       <= '0;
      espera_q    <= '0;
      premiados_q <= 3'd0;
      ultimo_q    <= 2'd0;
      numero_q    <= 4'd0;
      insere_q    <= 1'b0;
      fim_q       <= 1'b0;
      fim_jogo_q  <= 1'b0;
      ocupado_q   <= 1'b0;
      pronto_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      qtd_q       <= qtd_d;
      jogo_q      <= jogo_d;
      pos_q       <= pos_d;
      espera_q    <= espera_d;
      premiados_q <= premiados_d;
      ultimo_q    <= ultimo_d;
      numero_q    <= numero_d;
      insere_q    <= insere_d;
      fim_q       <= fim_d;
      fim_jogo_q  <= fim_jogo_d;
      ocupado_q   <= ocupado_d;
      pronto_q    <= pronto_d;
    end
  end

  // Next-state logic: walk each bet through send, close, wait/sample, then finish the run.
  always_comb begin
    state_d      = state_q;
    qtd_d        = qtd_q;
    jogo_d       = jogo_q;
    pos_d        = pos_q;
    espera_d     = espera_q;
    premiados_d  = premiados_q;
    ultimo_d     = ultimo_q;
    qtd_valida_s = (qtd_jogos != 3'd0) && ({29'd0, qtd_jogos} <= MAX_JOGOS);
    case (state_q)
      OCIOSO: begin
        if (inicia && qtd_valida_s) begin
          state_d     = ENVIA;
          qtd_d       = qtd_jogos;
          jogo_d      = 3'd0;
          pos_d       = '0;
          premiados_d = 3'd0;
          ultimo_d    = 2'd0;
        end else begin
          state_d = OCIOSO;
        end
      end
      ENVIA: begin
        if (pos_q == ULT_POS) begin
          state_d = FECHA;
          pos_d   = '0;
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end
      FECHA: begin
        state_d  = AGUARDA;
        espera_d = ESPERA_L;
      end
      AGUARDA: begin
        if (espera_q == WW'(1)) begin
          // Final wait edge: this is the only point where premio is observed.
          ultimo_d = premio;
          if (premio != 2'd0) begin
            premiados_d = premiados_q + 3'd1;
          end else begin
            premiados_d = premiados_q;
          end
          if (jogo_q == (qtd_q - 3'd1)) begin
            state_d = FINALIZA;
          end else begin
            state_d = ENVIA;
            jogo_d  = jogo_q + 3'd1;
            pos_d   = '0;
          end
        end else begin
          espera_d = espera_q - WW'(1);
        end
      end
      FINALIZA: begin
        state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // Output logic: decode the upcoming state so outputs are registered yet cycle-aligned.
  always_comb begin
    rd_addr_s  = AW'((32'(jogo_d) * 32'(NUM_POR_JOGO)) + 32'(pos_d));
    insere_d   = 1'b0;
    numero_d   = 4'd0;
    fim_d      = 1'b0;
    fim_jogo_d = 1'b0;
    pronto_d   = 1'b0;
    ocupado_d  = 1'b1;
    case (state_d)
      OCIOSO: begin
        ocupado_d = 1'b0;
      end
      ENVIA: begin
        insere_d = 1'b1;
        numero_d = mem_q[rd_addr_s];
      end
      FECHA: begin
        fim_d = 1'b1;
      end
      AGUARDA: begin
        ocupado_d = 1'b1;
      end
      FINALIZA: begin
        fim_jogo_d = 1'b1;
        pronto_d   = 1'b1;
      end
      default: begin
        ocupado_d = 1'b0;
      end
    endcase
  end

  assign numero        = numero_q;
  assign insere        = insere_q;
  assign fim           = fim_q;
  assign fim_jogo      = fim_jogo_q;
  assign ocupado       = ocupado_q;
  assign pronto        = pronto_q;
  assign premiados     = premiados_q;
  assign ultimo_premio = ultimo_q;

endmodule
